branch_resolve_bht: RTL and testbench
=====================================

BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001: Parameter XLEN, default 32, width of all PC ports.
REQ-002: Parameter BHT_ENTRIES, default 16, number of 2-bit counters; SHALL be a power of two and at least 2.
REQ-003: Parameter CNT_W, default 16, width of each statistics counter.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: fetch_pc  input  XLEN  PC of the instruction being fetched.
REQ-007: pred_taken  output  1  combinational prediction for fetch_pc.
REQ-008: ex_valid  input  1  a control-transfer candidate is resolving in EX this cycle.
REQ-009: ex_pc  input  XLEN  PC of the resolving instruction.
REQ-010: ex_instr  input  32  resolving instruction word; funct3 = ex_instr[14:12].
REQ-011: ex_pred_taken  input  1  prediction made at fetch for the resolving instruction.
REQ-012: branch, jump, zero, lt, ltu  input  1 each  decoder controls and ALU compare flags.
REQ-013: pc_src  output  1  combinational resolved-taken.
REQ-014: flush  output  1  registered one-cycle mispredict pulse.
REQ-015: illegal_br  output  1  combinational; branch with funct3 010 or 011.
REQ-016: stat_br, stat_mis  output  CNT_W each  resolved-branch and mispredict counts.

Function
REQ-017: Index = pc[2 +: log2(BHT_ENTRIES)] for both fetch_pc (read) and ex_pc (update).
REQ-018: pred_taken = bit 1 of the counter at the fetch_pc index.
REQ-019: Branch taken per funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 not taken with illegal_br=1.
REQ-020: pc_src = jump | (branch & taken); with jump=1 branch is ignored; with ex_valid=0, pc_src = 0.
REQ-021: illegal_br asserts only when ex_valid & branch & !jump.
REQ-022: Update: on ex_valid & branch & !jump & !illegal_br, the counter at the ex_pc index increments if taken, decrements if not; saturates at 3 and 0.
REQ-023: Jumps and illegal branches do not modify the BHT.
REQ-024: mispredict = ex_valid & (branch|jump) & !illegal_br & (pc_src != ex_pred_taken); flush = mispredict registered, high exactly one cycle per mispredicting resolve.
REQ-025: Back-to-back mispredicts produce flush high in consecutive cycles.
REQ-026: Same-cycle read and write of one index: pred_taken shows the pre-update value; the new value is visible from the next cycle.
REQ-027: stat_br increments on each BHT update event; stat_mis increments on each mispredict (branch or jump); both saturate at all-ones.

Reset
REQ-028: While rst=1 at a rising edge: all BHT counters = 2'b01 (weakly not-taken), flush=0, stat_br=0, stat_mis=0; update and count events in that cycle are discarded.
REQ-029: Reset mid-operation cancels a pending flush; flush=0 in the cycle after the reset edge.
REQ-030: pc_src and illegal_br remain combinational and are unaffected by rst.

Verification
REQ-031: After reset, fetch_pc=0x00000010 -> pred_taken=0; branch=1, ex_instr=0x02528063 (beq), zero=1, ex_pred_taken=0, ex_pc=0x10 -> pc_src=1, flush=1 next cycle, stat_mis=1, stat_br=1.
REQ-032: Repeat the REQ-031 beq at ex_pc=0x10 three times -> counter 01->10->11->11; pred_taken at fetch_pc=0x10 = 1 after the first update; fetch_pc=0x50 (same index 4) also predicts 1.
REQ-033: Sweep 0x00529e63/0x0052cc63/0x0052da63/0x0052e863/0x0052f663 with each flag at 0 and 1 -> pc_src = !zero, lt, !lt, ltu, !ltu respectively.
REQ-034: jump=1, branch=0, ex_instr=0x008002ef then 0x100302e7, ex_pred_taken=0 -> pc_src=1, flush pulses twice consecutively, BHT unchanged, stat_br unchanged.
REQ-035: branch=1, ex_instr with funct3=010 -> illegal_br=1, pc_src=0, no flush, no BHT or stat change.
REQ-036: Mispredict at edge N, rst=1 at edge N+1 -> flush=0 after N+1; all indices predict 0; stats=0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// Branch resolution in EX plus a bimodal 2-bit branch history table read at fetch.
// Also drives the registered mispredict flush and the branch/mispredict statistics.
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [31:0]      ex_instr,
    input  logic             ex_pred_taken,
    input  logic             branch,
    input  logic             jump,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    output logic             pc_src,
    output logic             flush,
    output logic             illegal_br,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_mis
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [2:0]       funct3;
    logic             br_taken;
    logic             funct3_bad;
    logic             is_br;
    logic             bht_upd;
    logic             mispredict;
    logic             unused_ok;

    function automatic logic [1:0] sat_cnt2(input logic [1:0] cnt, input logic up);
        if (up)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

    assign fetch_idx  = fetch_pc[2 +: IDX_W];
    assign ex_idx     = ex_pc[2 +: IDX_W];
    assign funct3     = ex_instr[14:12];
    assign pred_taken = bht[fetch_idx][1];

    always_comb begin
        br_taken   = 1'b0;
        funct3_bad = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: funct3_bad = 1'b1;
        endcase
    end

    // A jump overrides the branch decode entirely, including the illegal check.
    assign is_br      = ex_valid & branch & !jump;
    assign illegal_br = is_br & funct3_bad;
    assign pc_src     = ex_valid & (jump | (branch & br_taken));
    assign bht_upd    = is_br & !funct3_bad;
    assign mispredict = ex_valid & (branch | jump) & !illegal_br & (pc_src != ex_pred_taken);

    assign unused_ok = ^{fetch_pc[1:0], fetch_pc[XLEN-1:IDX_W+2],
                         ex_pc[1:0], ex_pc[XLEN-1:IDX_W+2],
                         ex_instr[31:15], ex_instr[11:0]};

    // Stage p1: table write, flush pulse and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
            flush    <= 1'b0;
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (bht_upd) begin
                bht[ex_idx] <= sat_cnt2(bht[ex_idx], br_taken);
                stat_br     <= sat_inc(stat_br);
            end
            if (mispredict)
                stat_mis <= sat_inc(stat_mis);
            flush <= mispredict;
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: resolve, BHT training, flush pulses and reset.
module tb_branch_resolve_bht;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic        ex_pred_taken;
    logic        branch, jump, zero, lt, ltu;
    logic        pc_src, flush, illegal_br;
    logic [15:0] stat_br, stat_mis;

    int checks = 0;
    int errors = 0;

    branch_resolve_bht dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_pred_taken(ex_pred_taken), .branch(branch), .jump(jump),
        .zero(zero), .lt(lt), .ltu(ltu), .pc_src(pc_src), .flush(flush),
        .illegal_br(illegal_br), .stat_br(stat_br), .stat_mis(stat_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] instr,
                           input logic br, input logic jmp, input logic z,
                           input logic pp);
        @(negedge clk);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_instr      = instr;
        branch        = br;
        jump          = jmp;
        zero          = z;
        lt            = 1'b0;
        ltu           = 1'b0;
        ex_pred_taken = pp;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        ex_valid = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        #1;
    endtask

    logic [31:0] sweep_instr [5];
    logic [2:0]  sweep_sel   [5];

    initial begin
        sweep_instr = '{32'h00529e63, 32'h0052cc63, 32'h0052da63, 32'h0052e863, 32'h0052f663};
        sweep_sel   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

        rst = 1'b1; fetch_pc = 32'h10; ex_valid = 1'b0; ex_pc = '0; ex_instr = '0;
        ex_pred_taken = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        tick(); tick();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_stat_br", {16'd0, stat_br}, 32'd0);
        chk("rst_stat_mis", {16'd0, stat_mis}, 32'd0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // beq taken, predicted not taken
        resolve(32'h10, 32'h02528063, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("beq_pc_src", {31'd0, pc_src}, 32'd1);
        chk("beq_pred_pre_update", {31'd0, pred_taken}, 32'd0);
        chk("beq_illegal", {31'd0, illegal_br}, 32'd0);
        tick();
        chk("beq_flush", {31'd0, flush}, 32'd1);
        chk("beq_stat_br", {16'd0, stat_br}, 32'd1);
        chk("beq_stat_mis", {16'd0, stat_mis}, 32'd1);
        chk("beq_pred_post", {31'd0, pred_taken}, 32'd1);

        // two more taken updates, predicted correctly: counter saturates at 11
        resolve(32'h10, 32'h02528063, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rep2_flush", {31'd0, flush}, 32'd0);
        chk("rep2_stat_br", {16'd0, stat_br}, 32'd2);
        resolve(32'h10, 32'h02528063, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rep3_stat_br", {16'd0, stat_br}, 32'd3);
        chk("rep3_stat_mis", {16'd0, stat_mis}, 32'd1);
        chk("rep3_pred_sat", {31'd0, pred_taken}, 32'd1);
        idle();
        fetch_pc = 32'h50;
        #1;
        chk("alias_pred_0x50", {31'd0, pred_taken}, 32'd1);
        fetch_pc = 32'h10;

        // two not-taken mispredicts back to back: 11 -> 10 -> 01
        resolve(32'h10, 32'h02528063, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("nt1_pc_src", {31'd0, pc_src}, 32'd0);
        tick();
        chk("nt1_flush", {31'd0, flush}, 32'd1);
        chk("nt1_pred", {31'd0, pred_taken}, 32'd1);
        resolve(32'h10, 32'h02528063, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("nt2_flush_consec", {31'd0, flush}, 32'd1);
        chk("nt2_pred", {31'd0, pred_taken}, 32'd0);
        chk("nt2_stat_br", {16'd0, stat_br}, 32'd5);
        chk("nt2_stat_mis", {16'd0, stat_mis}, 32'd3);
        idle();
        tick();
        chk("nt_flush_drop", {31'd0, flush}, 32'd0);

        // funct3 sweep, combinational only: ex_valid drops before each rising edge
        for (int k = 0; k < 5; k++) begin
            for (int f = 0; f < 2; f++) begin
                logic exp_t;
                @(negedge clk);
                ex_valid = 1'b1; ex_pc = 32'h20; ex_instr = sweep_instr[k];
                branch = 1'b1; jump = 1'b0; ex_pred_taken = 1'b0;
                zero = (sweep_sel[k] == 3'd1) ? f[0] : 1'b0;
                lt   = (sweep_sel[k] == 3'd2 || sweep_sel[k] == 3'd3) ? f[0] : 1'b0;
                ltu  = (sweep_sel[k] == 3'd4 || sweep_sel[k] == 3'd5) ? f[0] : 1'b0;
                exp_t = (sweep_sel[k] == 3'd2 || sweep_sel[k] == 3'd4) ? f[0] : !f[0];
                #1;
                chk($sformatf("sweep_%0h_f%0d", sweep_instr[k], f), {31'd0, pc_src}, {31'd0, exp_t});
                ex_valid = 1'b0;
            end
        end
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;

        // jal then jalr (with branch also raised and a beq funct3 not taken)
        resolve(32'h10, 32'h008002ef, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jal_pc_src", {31'd0, pc_src}, 32'd1);
        tick();
        chk("jal_flush", {31'd0, flush}, 32'd1);
        resolve(32'h10, 32'h100302e7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("jalr_pc_src", {31'd0, pc_src}, 32'd1);
        tick();
        chk("jalr_flush_consec", {31'd0, flush}, 32'd1);
        chk("jump_stat_br", {16'd0, stat_br}, 32'd5);
        chk("jump_stat_mis", {16'd0, stat_mis}, 32'd5);
        idle();
        chk("jump_bht_unchanged", {31'd0, pred_taken}, 32'd0);
        chk("idle_illegal", {31'd0, illegal_br}, 32'd0);

        // illegal funct3 010, predicted taken
        resolve(32'h10, 32'h0052a063, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ill_flag", {31'd0, illegal_br}, 32'd1);
        chk("ill_pc_src", {31'd0, pc_src}, 32'd0);
        tick();
        chk("ill_flush", {31'd0, flush}, 32'd0);
        chk("ill_stat_br", {16'd0, stat_br}, 32'd5);
        chk("ill_stat_mis", {16'd0, stat_mis}, 32'd5);
        idle();
        chk("ill_bht_unchanged", {31'd0, pred_taken}, 32'd0);

        // mispredict at edge N, reset at edge N+1 with an update still presented
        resolve(32'h30, 32'h02528063, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pc_src_comb", {31'd0, pc_src}, 32'd1);
        tick();
        chk("rst_cancel_flush", {31'd0, flush}, 32'd0);
        chk("rst2_stat_br", {16'd0, stat_br}, 32'd0);
        chk("rst2_stat_mis", {16'd0, stat_mis}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0; branch = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fetch_pc = 32'(i) << 2;
            #1;
            chk($sformatf("rst_idx%0d_pred", i), {31'd0, pred_taken}, 32'd0);
        end
        tick();
        chk("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
